// File: rtl/gray_mem_arb.sv
// Two-requester round-robin arbiter in front of a gray image read port.
// Grants bursts of up to 16 beats and routes returned pixels back to the owning requester.
module gray_mem_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [13:0] m0_addr,
  input  logic        m0_last,
  input  logic        m1_req,
  input  logic [13:0] m1_addr,
  input  logic        m1_last,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_valid,
  output logic        m1_valid,
  output logic [7:0]  m0_data,
  output logic [7:0]  m1_data,
  output logic        gray_req,
  output logic [13:0] gray_addr,
  input  logic        gray_ready,
  input  logic [7:0]  gray_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [4:0]  beatCnt_q, beatCnt_d;
  logic        valid0_q, valid1_q;
  logic        curReq, curLast, accept;
  logic [13:0] curAddr;

  always_comb begin
    curReq  = 1'b0;
    curLast = 1'b0;
    curAddr = 14'd0;
    case (state_q)
      GNT0: begin
        curReq  = m0_req;
        curLast = m0_last;
        curAddr = m0_addr;
      end
      GNT1: begin
        curReq  = m1_req;
        curLast = m1_last;
        curAddr = m1_addr;
      end
      default: ;
    endcase
    accept    = curReq & gray_ready;
    gray_req  = curReq;
    gray_addr = curAddr;
  end

  // A burst ends on its last beat, on the 16th beat, or as soon as the owner drops req.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    beatCnt_d = beatCnt_q;
    case (state_q)
      IDLE: begin
        beatCnt_d = 5'd0;
        if (m0_req && m1_req) state_d = prio_q ? GNT1 : GNT0;
        else if (m0_req)      state_d = GNT0;
        else if (m1_req)      state_d = GNT1;
      end
      default: begin
        if (accept) beatCnt_d = beatCnt_q + 5'd1;
        if (!curReq || (accept && (curLast || beatCnt_q == 5'd15))) begin
          state_d = IDLE;
          prio_d  = (state_q == GNT0);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      beatCnt_q <= 5'd0;
      valid0_q  <= 1'b0;
      valid1_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      beatCnt_q <= beatCnt_d;
      valid0_q  <= accept && (state_q == GNT0);
      valid1_q  <= accept && (state_q == GNT1);
    end
  end

  assign m0_gnt   = (state_q == GNT0);
  assign m1_gnt   = (state_q == GNT1);
  assign busy     = (state_q != IDLE);
  assign m0_valid = valid0_q;
  assign m1_valid = valid1_q;
  assign m0_data  = valid0_q ? gray_data : 8'd0;
  assign m1_data  = valid1_q ? gray_data : 8'd0;

endmodule

// File: tb/tb_gray_mem_arb.sv
// Randomized and directed bench for gray_mem_arb against a transaction-level ownership model.
module tb_gray_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_last, m1_req, m1_last;
  logic [13:0] m0_addr, m1_addr;
  logic        m0_gnt, m1_gnt, m0_valid, m1_valid;
  logic [7:0]  m0_data, m1_data;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic        gray_ready;
  logic [7:0]  gray_data;
  logic        busy;

  int checkCount = 0;
  int failCount  = 0;

  // Model: who owns the port (-1 = nobody), beats served, round-robin pointer, pending return.
  int          owner, prio, beats, pendOwner;
  logic [13:0] pendAddr;

  gray_mem_arb dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_last(m0_last),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_last(m1_last),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_valid(m0_valid), .m1_valid(m1_valid),
    .m0_data(m0_data), .m1_data(m1_data),
    .gray_req(gray_req), .gray_addr(gray_addr),
    .gray_ready(gray_ready), .gray_data(gray_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memFn(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    owner     = -1;
    prio      = 0;
    beats     = 0;
    pendOwner = -1;
    pendAddr  = 14'd0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".m0_gnt"},    32'(m0_gnt),    32'd0);
    checkOutput({tag, ".m1_gnt"},    32'(m1_gnt),    32'd0);
    checkOutput({tag, ".busy"},      32'(busy),      32'd0);
    checkOutput({tag, ".gray_req"},  32'(gray_req),  32'd0);
    checkOutput({tag, ".gray_addr"}, 32'(gray_addr), 32'd0);
    checkOutput({tag, ".m0_valid"},  32'(m0_valid),  32'd0);
    checkOutput({tag, ".m1_valid"},  32'(m1_valid),  32'd0);
    checkOutput({tag, ".m0_data"},   32'(m0_data),   32'd0);
    checkOutput({tag, ".m1_data"},   32'(m1_data),   32'd0);
  endtask

  task automatic zeroInputs();
    m0_req = 0; m0_addr = 0; m0_last = 0;
    m1_req = 0; m1_addr = 0; m1_last = 0;
    gray_ready = 0;
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic applyStimulus(input logic r0, input logic [13:0] a0, input logic l0,
                               input logic r1, input logic [13:0] a1, input logic l1,
                               input logic rdy);
    logic        rq [2];
    logic [13:0] ad [2];
    logic        ls [2];
    logic        expReq;
    logic [13:0] expAddr;
    bit          acc;
    rq[0] = r0; ad[0] = a0; ls[0] = l0;
    rq[1] = r1; ad[1] = a1; ls[1] = l1;
    @(negedge clk);
    m0_req = r0; m0_addr = a0; m0_last = l0;
    m1_req = r1; m1_addr = a1; m1_last = l1;
    gray_ready = rdy;
    gray_data  = (pendOwner >= 0) ? memFn(pendAddr) : 8'($urandom);
    #1;
    expReq  = (owner >= 0) ? rq[owner] : 1'b0;
    expAddr = (owner >= 0) ? ad[owner] : 14'd0;
    checkOutput("m0_gnt",    32'(m0_gnt),    32'(owner == 0));
    checkOutput("m1_gnt",    32'(m1_gnt),    32'(owner == 1));
    checkOutput("busy",      32'(busy),      32'(owner >= 0));
    checkOutput("gray_req",  32'(gray_req),  32'(expReq));
    checkOutput("gray_addr", 32'(gray_addr), 32'(expAddr));
    checkOutput("m0_valid",  32'(m0_valid),  32'(pendOwner == 0));
    checkOutput("m1_valid",  32'(m1_valid),  32'(pendOwner == 1));
    checkOutput("m0_data",   32'(m0_data),   (pendOwner == 0) ? 32'(memFn(pendAddr)) : 32'd0);
    checkOutput("m1_data",   32'(m1_data),   (pendOwner == 1) ? 32'(memFn(pendAddr)) : 32'd0);

    acc = (owner >= 0) && rq[owner] && rdy;
    if (acc) begin
      pendOwner = owner;
      pendAddr  = ad[owner];
    end else begin
      pendOwner = -1;
    end
    if (owner < 0) begin
      beats = 0;
      if (r0 && r1) owner = prio;
      else if (r0)  owner = 0;
      else if (r1)  owner = 1;
    end else begin
      if (acc) beats++;
      if (!rq[owner] || (acc && (ls[owner] || beats == 16))) begin
        prio  = 1 - owner;
        owner = -1;
      end
    end
  endtask

  // Reset asserted asynchronously mid-cycle; outputs must clear before any clock edge.
  task automatic doReset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 checkAllZero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    zeroInputs();
    modelReset();
  endtask

  initial begin
    int k;
    reset = 1'b1;
    zeroInputs();
    gray_data = 8'hA5;
    modelReset();
    @(negedge clk);
    #1 checkAllZero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Single-beat read of 0x0081.
    applyStimulus(1, 14'h0081, 1, 0, 0, 0, 1);
    applyStimulus(1, 14'h0081, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Tie out of reset: m0 first, then m1, then m0 again on the next tie.
    doReset();
    applyStimulus(1, 14'h0010, 0, 1, 14'h0200, 0, 1);
    applyStimulus(1, 14'h0011, 1, 1, 14'h0200, 0, 1);
    applyStimulus(0, 0, 0, 1, 14'h0200, 0, 1);
    applyStimulus(0, 0, 0, 1, 14'h0200, 1, 1);
    applyStimulus(1, 14'h0020, 0, 1, 14'h0300, 0, 1);
    applyStimulus(1, 14'h0020, 1, 1, 14'h0300, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // m1 streams 20 beats without last; forced release after 16, m0 waiting.
    applyStimulus(0, 0, 0, 1, 14'h1000, 0, 1);
    for (int i = 0; i < 20; i++)
      applyStimulus((i >= 2), 14'h0400, 1, 1, 14'h1000 + 14'(i), 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Stall for three cycles mid-burst; address holds until accepted.
    k = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 14'h0100 + 14'(k), (i == 9), 0, 0, 0, !(i >= 4 && i < 7));
      if (i > 0 && !(i >= 4 && i < 7)) k++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Reset one cycle after an accepted beat discards the pending return.
    applyStimulus(1, 14'h0555, 0, 0, 0, 0, 1);
    applyStimulus(1, 14'h0555, 0, 0, 0, 0, 1);
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // m0 drops req after 5 beats; 5th beat still returns.
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 14'h0700 + 14'(i), 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) doReset();
      applyStimulus(($urandom_range(0, 3) != 0), 14'($urandom), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) != 0), 14'($urandom), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
